retro_memory_arbiter: RTL and testbench
=======================================

// Module: retro_memory_arbiter
// PURPOSE
//  Shares one IRetroMemoryPort Target among Requesters initiators using round-robin arbitration.
//  Tracks outstanding reads in a tag FIFO so FIFO-ordered read data is steered back to its issuer.
//  Sits between CPU/video/DMA initiators and the memory controller.
//  Works with both always-ready SRAM targets and long-latency DRAM targets.
// PARAMETERS
//  Requesters       4   number of initiator ports, 2..8
//  AddressBusWidth  23  address width, all ports
//  DataBusWidth     1   data width in bytes, all ports
//  TagDepth         8   max outstanding reads; power of 2, >=2
// PORTS
//  Clk              in   1        clock, all logic rising-edge
//  Reset            in   1        asynchronous, active-high
//  ReqAddress       in   R*AW     per-requester address, slice i = requester i
//  ReqDToTarget     in   R*8*DW   per-requester write data
//  ReqAccess        in   R        requester i presents a command
//  ReqMask          in   R*DW     per-requester byte mask, 0 = byte not written
//  ReqWrite         in   R        1 = write, 0 = read
//  ReqReady         out  R        command of requester i accepted this cycle
//  ReqDataReady     out  R        read data on ReqDToInitiator belongs to requester i
//  ReqDToInitiator  out  8*DW     read data, broadcast to all requesters
//  MemAddress       out  AW       to target Address
//  MemDToTarget     out  8*DW     to target DToTarget
//  MemAccess        out  1        to target Access
//  MemMask          out  DW       to target Mask
//  MemWrite         out  1        to target Write
//  MemReady         in   1        from target Ready
//  MemDataReady     in   1        from target DataReady
//  MemDToInitiator  in   8*DW     from target DToInitiator
//  ProtocolError    out  1        sticky: DataReady arrived with no read outstanding
// BEHAVIOUR
//  - Reset values: Ptr=0, tag FIFO empty, ProtocolError=0. While Reset is high: MemAccess=0, ReqReady=0, ReqDataReady=0.
//  - A requester is eligible when ReqAccess[i]=1 and (ReqWrite[i]=1 or the tag FIFO is not full).
//  - Grant: the first eligible requester scanning Ptr, Ptr+1, ... mod R. Grant is combinational from Ptr and the eligibility vector.
//  - Mem* command outputs mux the granted requester's signals.
//  - MemAccess = any eligible requester. With none eligible, Mem* data/address hold requester Ptr's values and MemAccess=0.
//  - Transfer: ReqReady[g] = MemAccess & MemReady. Command fall-through has zero cycles of latency.
//  - After a transfer: Ptr <= g+1 mod R. With no transfer, Ptr holds.
//  - Read transfer pushes tag g into the tag FIFO. Write transfer pushes nothing.
//  - Response: when MemDataReady=1 and the FIFO is not empty, ReqDataReady[head]=1 (one-hot) and the head is popped.
//  - ReqDToInitiator = MemDToInitiator, combinational, zero latency.
//  - Empty FIFO with MemDataReady=1: every ReqDataReady stays 0, nothing pops, ProtocolError <= 1 (sticky until Reset).
//  - Full FIFO: reads are ineligible even when a pop happens in the same cycle. Writes still pass. This avoids a MemDataReady->ReqReady path.
//  - Same-cycle push and pop on a non-full FIFO: both happen and the count is unchanged.
//  - Pointers wrap modulo TagDepth. The count is log2(TagDepth)+1 bits.
//  - Reset mid-operation clears all tags. Responses still in flight in the target then arrive with an empty FIFO and raise ProtocolError. The target must be reset together with the arbiter.
//  - ReqAccess must hold stable with its command until ReqReady is seen. The arbiter does not latch commands.
// CONFIGURATION
//  - RETRO_MEMARB_LOCK_EN defined: adds input ReqLock [R].
//  - With LOCK: while the last granted requester g holds ReqLock[g]=1 and ReqAccess[g]=1, it keeps the grant (Ptr stays at g) for burst sequences.
//  - With LOCK: a lock held while g is ineligible (read with FIFO full) stalls all requesters. This is intentional; it preserves burst atomicity.
//  - Not defined: no ReqLock port; pure round-robin as above.
// TESTING
//  - Reset: assert Reset with all ReqAccess=1 -> MemAccess=0, ReqReady=0. Release -> requester 0 is granted first.
//  - Fairness: R=4, all requesters reading continuously, MemReady=1 -> grants 0,1,2,3,0,...; each requester gets one grant per 4 cycles.
//  - Ordering: req1 reads A, req3 reads B; target returns D1 then D2 3 cycles later -> ReqDataReady=0010 with D1, then 1000 with D2.
//  - FIFO full: TagDepth=8, 8 reads outstanding -> a 9th read has ReqReady=0; a concurrent write from another requester is accepted; after one MemDataReady the read is accepted next cycle.
//  - Empty response: MemDataReady=1 with no reads outstanding -> ReqDataReady=0 and ProtocolError=1 until Reset.
//  - LOCK (macro on): req2 holds ReqLock with 4 writes while req0 waits -> 4 consecutive req2 grants; req0 is granted after the lock drops.

Source files
------------

// File: rtl/retro_memory_arbiter.sv
// Round-robin arbiter sharing one retro memory port, with a read-tag FIFO.
// Optional RETRO_MEMARB_LOCK_EN adds ReqLock for atomic burst grants.
module retro_memory_arbiter #(
    parameter int Requesters      = 4,
    parameter int AddressBusWidth = 23,
    parameter int DataBusWidth    = 1,
    parameter int TagDepth        = 8
) (
    input  logic                                   Clk,
    input  logic                                   Reset,
    input  logic [Requesters*AddressBusWidth-1:0]  ReqAddress,
    input  logic [Requesters*8*DataBusWidth-1:0]   ReqDToTarget,
    input  logic [Requesters-1:0]                  ReqAccess,
    input  logic [Requesters*DataBusWidth-1:0]     ReqMask,
    input  logic [Requesters-1:0]                  ReqWrite,
`ifdef RETRO_MEMARB_LOCK_EN
    input  logic [Requesters-1:0]                  ReqLock,
`endif
    output logic [Requesters-1:0]                  ReqReady,
    output logic [Requesters-1:0]                  ReqDataReady,
    output logic [8*DataBusWidth-1:0]              ReqDToInitiator,
    output logic [AddressBusWidth-1:0]             MemAddress,
    output logic [8*DataBusWidth-1:0]              MemDToTarget,
    output logic                                   MemAccess,
    output logic [DataBusWidth-1:0]                MemMask,
    output logic                                   MemWrite,
    input  logic                                   MemReady,
    input  logic                                   MemDataReady,
    input  logic [8*DataBusWidth-1:0]              MemDToInitiator,
    output logic                                   ProtocolError
);

    localparam int PW = (Requesters > 1) ? $clog2(Requesters) : 1;
    localparam int TW = $clog2(TagDepth);
    localparam int BW = 8 * DataBusWidth;

    logic [PW-1:0]   ptr_q, ptr_d;
    logic [PW-1:0]   tags_q [TagDepth];
    logic [TW-1:0]   wr_ptr_q, wr_ptr_d;
    logic [TW-1:0]   rd_ptr_q, rd_ptr_d;
    logic [TW:0]     cnt_q, cnt_d;
    logic            pe_q, pe_d;

    logic                  full, empty;
    logic [Requesters-1:0] elig, elig_m;
    logic [PW-1:0]         gnt, idx, head;
    logic                  any, transfer, push, pop;

    assign full  = (cnt_q == (TW+1)'(TagDepth));
    assign empty = (cnt_q == '0);
    assign elig  = ReqAccess & (ReqWrite | {Requesters{~full}});

`ifdef RETRO_MEMARB_LOCK_EN
    logic lock_q, lock_d, locked;
    // A held lock restricts the grant to the locked owner, even if it stalls.
    assign locked = lock_q & ReqLock[ptr_q] & ReqAccess[ptr_q];
    assign elig_m = locked ? (elig & (Requesters'(1) << ptr_q)) : elig;
`else
    assign elig_m = elig;
`endif

    always_comb begin
        gnt = ptr_q;
        idx = ptr_q;
        any = 1'b0;
        for (int k = Requesters - 1; k >= 0; k--) begin
            idx = PW'((int'(ptr_q) + k) % Requesters);
            if (elig_m[idx]) begin
                gnt = idx;
                any = 1'b1;
            end
        end
    end

    assign MemAddress   = ReqAddress[int'(gnt)*AddressBusWidth +: AddressBusWidth];
    assign MemDToTarget = ReqDToTarget[int'(gnt)*BW +: BW];
    assign MemMask      = ReqMask[int'(gnt)*DataBusWidth +: DataBusWidth];
    assign MemWrite     = ReqWrite[gnt];
    assign MemAccess    = any & ~Reset;

    assign transfer = MemAccess & MemReady;
    assign push     = transfer & ~MemWrite;
    assign pop      = MemDataReady & ~empty & ~Reset;
    assign head     = tags_q[rd_ptr_q];

    assign ReqReady        = transfer ? (Requesters'(1) << gnt) : '0;
    assign ReqDataReady    = pop ? (Requesters'(1) << head) : '0;
    assign ReqDToInitiator = MemDToInitiator;
    assign ProtocolError   = pe_q;

    always_comb begin
        ptr_d    = ptr_q;
        wr_ptr_d = wr_ptr_q + TW'(push);
        rd_ptr_d = rd_ptr_q + TW'(pop);
        cnt_d    = cnt_q + (TW+1)'(push) - (TW+1)'(pop);
        pe_d     = pe_q | (MemDataReady & empty);
`ifdef RETRO_MEMARB_LOCK_EN
        lock_d   = lock_q;
`endif
        if (transfer) begin
            ptr_d = PW'((int'(gnt) + 1) % Requesters);
`ifdef RETRO_MEMARB_LOCK_EN
            lock_d = ReqLock[gnt];
            if (ReqLock[gnt]) ptr_d = gnt;
`endif
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            ptr_q    <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            pe_q     <= 1'b0;
            for (int i = 0; i < TagDepth; i++) tags_q[i] <= '0;
        end else begin
            ptr_q    <= ptr_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            pe_q     <= pe_d;
            if (push) tags_q[wr_ptr_q] <= gnt;
        end
    end

`ifdef RETRO_MEMARB_LOCK_EN
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) lock_q <= 1'b0;
        else       lock_q <= lock_d;
    end
`endif

endmodule

// File: tb/tb_retro_memory_arbiter.sv
// Directed self-checking bench for retro_memory_arbiter (R=4, TagDepth=8).
module tb_retro_memory_arbiter;

    localparam int R  = 4;
    localparam int AW = 23;
    localparam int DW = 1;

    logic            Clk = 1'b0;
    logic            Reset;
    logic [R*AW-1:0] ReqAddress;
    logic [R*8*DW-1:0] ReqDToTarget;
    logic [R-1:0]    ReqAccess;
    logic [R*DW-1:0] ReqMask;
    logic [R-1:0]    ReqWrite;
    logic [R-1:0]    ReqLock;
    logic [R-1:0]    ReqReady;
    logic [R-1:0]    ReqDataReady;
    logic [8*DW-1:0] ReqDToInitiator;
    logic [AW-1:0]   MemAddress;
    logic [8*DW-1:0] MemDToTarget;
    logic            MemAccess;
    logic [DW-1:0]   MemMask;
    logic            MemWrite;
    logic            MemReady;
    logic            MemDataReady;
    logic [8*DW-1:0] MemDToInitiator;
    logic            ProtocolError;

    int checks = 0;
    int errors = 0;

    retro_memory_arbiter #(
        .Requesters(R), .AddressBusWidth(AW),
        .DataBusWidth(DW), .TagDepth(8)
    ) dut (
        .Clk(Clk), .Reset(Reset),
        .ReqAddress(ReqAddress), .ReqDToTarget(ReqDToTarget),
        .ReqAccess(ReqAccess), .ReqMask(ReqMask), .ReqWrite(ReqWrite),
`ifdef RETRO_MEMARB_LOCK_EN
        .ReqLock(ReqLock),
`endif
        .ReqReady(ReqReady), .ReqDataReady(ReqDataReady),
        .ReqDToInitiator(ReqDToInitiator),
        .MemAddress(MemAddress), .MemDToTarget(MemDToTarget),
        .MemAccess(MemAccess), .MemMask(MemMask), .MemWrite(MemWrite),
        .MemReady(MemReady), .MemDataReady(MemDataReady),
        .MemDToInitiator(MemDToInitiator), .ProtocolError(ProtocolError)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    int drain [8] = '{1, 2, 3, 0, 1, 2, 3, 3};

    initial begin
        Reset = 1'b1;
        for (int i = 0; i < R; i++) begin
            ReqAddress[i*AW +: AW]   = AW'(32'h100 + i);
            ReqDToTarget[i*8 +: 8]   = 8'(32'hA0 + i);
        end
        ReqMask         = '1;
        ReqAccess       = 4'b1111;
        ReqWrite        = 4'b0000;
        ReqLock         = 4'b0000;
        MemReady        = 1'b1;
        MemDataReady    = 1'b0;
        MemDToInitiator = 8'h00;

        #1;
        chk("rst_access", 32'(MemAccess), 32'd0);
        chk("rst_ready", 32'(ReqReady), 32'd0);
        chk("rst_pe", 32'(ProtocolError), 32'd0);
        tick(); tick();
        MemDataReady = 1'b1;
        #1;
        chk("rst_dready", 32'(ReqDataReady), 32'd0);
        MemDataReady = 1'b0;
        Reset = 1'b0;
        #1;
        chk("rel_access", 32'(MemAccess), 32'd1);

        // All four read continuously: 0,1,2,3,0,1,2,3 fills the tag FIFO.
        for (int k = 0; k < 8; k++) begin
            chk("rr_grant", 32'(ReqReady), 32'(1 << (k % 4)));
            chk("rr_addr", 32'(MemAddress), 32'h100 + 32'(k % 4));
            tick();
        end

        chk("full_access", 32'(MemAccess), 32'd0);
        chk("full_ready", 32'(ReqReady), 32'd0);
        chk("full_hold_addr", 32'(MemAddress), 32'h100);

        ReqWrite = 4'b0100;
        #1;
        chk("full_wr_ready", 32'(ReqReady), 32'b0100);
        chk("full_wr_write", 32'(MemWrite), 32'd1);
        chk("full_wr_data", 32'(MemDToTarget), 32'hA2);
        tick();

        ReqWrite = 4'b0000;
        MemDataReady = 1'b1;
        MemDToInitiator = 8'h55;
        #1;
        chk("pop_dready", 32'(ReqDataReady), 32'b0001);
        chk("pop_data", 32'(ReqDToInitiator), 32'h55);
        chk("pop_rd_blocked", 32'(ReqReady), 32'd0);
        tick();

        MemDataReady = 1'b0;
        #1;
        chk("after_pop_rd", 32'(ReqReady), 32'b1000);
        tick();

        ReqAccess = 4'b0000;
        MemDataReady = 1'b1;
        for (int k = 0; k < 8; k++) begin
            MemDToInitiator = 8'(k);
            #1;
            chk("drain_tag", 32'(ReqDataReady), 32'(1 << drain[k]));
            chk("drain_data", 32'(ReqDToInitiator), 32'(k));
            tick();
        end

        chk("empty_dready", 32'(ReqDataReady), 32'd0);
        chk("empty_pe_pre", 32'(ProtocolError), 32'd0);
        tick();
        MemDataReady = 1'b0;
        chk("empty_pe_set", 32'(ProtocolError), 32'd1);
        tick();
        chk("empty_pe_sticky", 32'(ProtocolError), 32'd1);
        Reset = 1'b1;
        #1;
        chk("pe_cleared", 32'(ProtocolError), 32'd0);
        tick();
        Reset = 1'b0;

        ReqAccess = 4'b0010;
        #1;
        chk("ord_gnt1", 32'(ReqReady), 32'b0010);
        chk("ord_addr1", 32'(MemAddress), 32'h101);
        tick();
        ReqAccess = 4'b1000;
        #1;
        chk("ord_gnt3", 32'(ReqReady), 32'b1000);
        chk("ord_addr3", 32'(MemAddress), 32'h103);
        tick();
        ReqAccess = 4'b0000;
        MemDataReady = 1'b1;
        MemDToInitiator = 8'hD1;
        #1;
        chk("ord_resp1", 32'(ReqDataReady), 32'b0010);
        chk("ord_data1", 32'(ReqDToInitiator), 32'hD1);
        tick();
        MemDataReady = 1'b0;
        #1;
        chk("ord_gap", 32'(ReqDataReady), 32'd0);
        tick(); tick();
        MemDataReady = 1'b1;
        MemDToInitiator = 8'hD2;
        #1;
        chk("ord_resp2", 32'(ReqDataReady), 32'b1000);
        chk("ord_data2", 32'(ReqDToInitiator), 32'hD2);
        tick();
        MemDataReady = 1'b0;
        chk("ord_pe", 32'(ProtocolError), 32'd0);

        ReqAccess = 4'b0001;
        ReqWrite  = 4'b0001;
        MemReady  = 1'b0;
        #1;
        chk("nrdy_access", 32'(MemAccess), 32'd1);
        chk("nrdy_ready", 32'(ReqReady), 32'd0);
        tick();
        MemReady = 1'b1;
        #1;
        chk("nrdy_then", 32'(ReqReady), 32'b0001);
        tick();

`ifdef RETRO_MEMARB_LOCK_EN
        ReqWrite  = 4'b0101;
        ReqAccess = 4'b0100;
        ReqLock   = 4'b0100;
        #1;
        chk("lock_first", 32'(ReqReady), 32'b0100);
        tick();
        ReqAccess = 4'b0101;
        for (int k = 0; k < 3; k++) begin
            chk("lock_burst", 32'(ReqReady), 32'b0100);
            tick();
        end
        ReqAccess = 4'b0001;
        ReqLock   = 4'b0000;
        #1;
        chk("lock_release", 32'(ReqReady), 32'b0001);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
